if_prefetch_buffer: RTL and testbench

Parametrised instruction-fetch front end replacing the fixed single-register prefetch/IF-ID pair. It generates sequential fetch addresses, issues pipelined req/gnt requests to instruction memory with up to `MAX_OUTSTANDING` in flight, and buffers returned instructions with their PCs in a `DEPTH`-entry FIFO. The FIFO drains to the decode stage over a valid/ready handshake. A redirect from EX/branch logic flushes the FIFO and discards stale in-flight responses.

---
 rtl/if_pkg.sv | 12 +
 rtl/if_fifo.sv | 60 ++++++
 rtl/if_prefetch_buffer.sv | 97 +++++++++
 tb/tb_if_prefetch_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch buffer.
package if_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Power-of-two FIFO with synchronous reset and flush; the head is read
// straight from storage so it costs no extra register stage.
module if_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  entry_t                     push_data_i,
  input  logic                       pop_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign count_o = count;
  assign head_o  = mem[rptr];

  // A pop frees the slot at the same edge, so push into a full FIFO is legal then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data_i;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction-fetch front end: sequential PC generation, pipelined req/gnt
// memory requests, and a PC-tagged instruction FIFO feeding decode.
module if_prefetch_buffer
  import if_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        boot_addr_i,
  input  logic               fetch_enable_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_addr_i,
  output logic               instr_req_o,
  output logic [31:0]        instr_addr_o,
  input  logic               instr_gnt_i,
  input  logic               instr_rvalid_i,
  input  logic [INSTR_W-1:0] instr_rdata_i,
  output logic               id_valid_o,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [31:0]        id_pc_o,
  input  logic               id_ready_i
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit;
  logic          fifo_empty;
  logic          fifo_full;
  logic          grant;
  logic          rsp;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  always_comb begin
    // In-flight plus buffered entries never exceed DEPTH, so every response has a slot.
    credit      = {1'b0, fifo_count} + (CW+1)'(outstanding);
    instr_req_o = fetch_enable_i & ~redirect_i & ~rst_i & ~fifo_full
                & (outstanding < OW'(MAX_OUTSTANDING))
                & (credit < (CW+1)'(DEPTH));
    instr_addr_o = fetch_pc;
    grant        = instr_req_o & instr_gnt_i;
    rsp          = instr_rvalid_i & (outstanding != '0);
    push         = rsp & ~redirect_i & (discard == '0);
    id_valid_o   = ~fifo_empty & ~redirect_i & ~rst_i;
    pop          = id_valid_o & id_ready_i;
    push_entry   = '{pc: resp_pc, instr: instr_rdata_i};
    id_pc_o      = head.pc;
    id_instr_o   = head.instr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= boot_addr_i;
      resp_pc     <= boot_addr_i;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + OW'(grant) - OW'(rsp);
      if (redirect_i) begin
        fetch_pc <= redirect_addr_i;
        resp_pc  <= redirect_addr_i;
        discard  <= outstanding - OW'(rsp);
      end else begin
        if (grant) fetch_pc <= fetch_pc + PC_INC;
        if (push)  resp_pc  <= resp_pc + PC_INC;
        if (rsp && discard != '0) discard <= discard - OW'(1);
      end
    end
  end

  if_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Directed bench for if_prefetch_buffer with an in-order req/gnt memory model.
module tb_if_prefetch_buffer;
  import if_pkg::*;

  logic        clk;
  logic        rst_i;
  logic [31:0] boot_addr_i;
  logic        fetch_enable_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_ready_i;

  int vectors;
  int miscompares;

  logic        mem_gnt_en;
  logic        mem_resp_en;
  logic [31:0] pend[$];
  logic        granted;
  logic [31:0] gaddr;

  if_prefetch_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .boot_addr_i(boot_addr_i),
    .fetch_enable_i(fetch_enable_i), .redirect_i(redirect_i),
    .redirect_addr_i(redirect_addr_i), .instr_req_o(instr_req_o),
    .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .id_valid_o(id_valid_o), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
    .id_ready_i(id_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Drive this cycle's memory outputs from the pending-request queue, then settle.
  task automatic prep();
    if (!rst_i && mem_resp_en && pend.size() != 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = rdata_of(pend[0]);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
    end
    instr_gnt_i = mem_gnt_en;
    #1;
  endtask

  task automatic adv();
    granted = instr_req_o && instr_gnt_i;
    gaddr   = instr_addr_o;
    @(posedge clk);
    if (instr_rvalid_i) void'(pend.pop_front());
    if (granted) pend.push_back(gaddr);
    if (rst_i) pend.delete();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] boot);
    boot_addr_i = boot;
    rst_i = 1'b1;
    redirect_i = 1'b0;
    prep(); adv();
    prep(); adv();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    boot_addr_i = 32'h8000_0000;
    fetch_enable_i = 1'b1; id_ready_i = 1'b1; mem_gnt_en = 1'b1; mem_resp_en = 1'b1;
    rst_i = 1'b1; redirect_i = 1'b0;
    prep(); adv(); prep();
    vectors++; if (instr_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b exp 0", instr_req_o); end
    vectors++; if (id_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", id_valid_o); end
    vectors++; if (id_instr_o !== 32'h0) begin miscompares++; $display("FAIL rst_instr got %h exp 0", id_instr_o); end
    vectors++; if (id_pc_o !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h exp 0", id_pc_o); end
    adv();
    rst_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      prep();
      exp = 32'h8000_0000 + 32'(4 * k);
      vectors++; if (instr_req_o !== 1'b1) begin miscompares++; $display("FAIL stream_req c%0d got %b exp 1", k, instr_req_o); end
      vectors++; if (instr_addr_o !== exp) begin miscompares++; $display("FAIL stream_addr c%0d got %h exp %h", k, instr_addr_o, exp); end
      if (k >= 2) begin
        exp = 32'h8000_0000 + 32'(4 * (k - 2));
        vectors++; if (id_valid_o !== 1'b1) begin miscompares++; $display("FAIL stream_valid c%0d got %b exp 1", k, id_valid_o); end
        vectors++; if (id_pc_o !== exp) begin miscompares++; $display("FAIL stream_pc c%0d got %h exp %h", k, id_pc_o, exp); end
        vectors++; if (id_instr_o !== rdata_of(exp)) begin miscompares++; $display("FAIL stream_instr c%0d got %h exp %h", k, id_instr_o, rdata_of(exp)); end
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    int grants = 0;
    int got = 0;
    logic [31:0] exp;
    id_ready_i = 1'b0; fetch_enable_i = 1'b1; mem_gnt_en = 1'b1; mem_resp_en = 1'b1;
    do_reset(32'h8000_0000);
    for (int c = 0; c < 10; c++) begin
      prep(); adv();
      if (granted) grants++;
    end
    prep();
    vectors++; if (grants !== 4) begin miscompares++; $display("FAIL bp_grants got %0d exp 4", grants); end
    vectors++; if (instr_req_o !== 1'b0) begin miscompares++; $display("FAIL bp_req_full got %b exp 0", instr_req_o); end
    vectors++; if (dut.fifo_count !== 3'd4) begin miscompares++; $display("FAIL bp_count got %0d exp 4", dut.fifo_count); end
    vectors++; if (id_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_valid got %b exp 1", id_valid_o); end
    adv();
    id_ready_i = 1'b1;
    for (int c = 0; c < 12 && got < 4; c++) begin
      prep();
      if (id_valid_o) begin
        exp = 32'h8000_0000 + 32'(4 * got);
        vectors++; if (id_pc_o !== exp) begin miscompares++; $display("FAIL bp_pc #%0d got %h exp %h", got, id_pc_o, exp); end
        vectors++; if (id_instr_o !== rdata_of(exp)) begin miscompares++; $display("FAIL bp_instr #%0d got %h exp %h", got, id_instr_o, rdata_of(exp)); end
        got++;
      end
      adv();
    end
    vectors++; if (got !== 4) begin miscompares++; $display("FAIL bp_delivered got %0d exp 4", got); end
  endtask

  task automatic test_redirect_outstanding();
    bit seen = 0;
    bit gseen = 0;
    id_ready_i = 1'b1; fetch_enable_i = 1'b1; mem_gnt_en = 1'b1; mem_resp_en = 1'b0;
    do_reset(32'h8000_0000);
    prep(); adv(); prep(); adv();
    prep();
    vectors++; if (dut.outstanding !== 2'd2) begin miscompares++; $display("FAIL rd_out got %0d exp 2", dut.outstanding); end
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_1000;
    prep();
    vectors++; if (instr_req_o !== 1'b0) begin miscompares++; $display("FAIL rd_req got %b exp 0", instr_req_o); end
    vectors++; if (id_valid_o !== 1'b0) begin miscompares++; $display("FAIL rd_valid got %b exp 0", id_valid_o); end
    adv();
    redirect_i = 1'b0; mem_resp_en = 1'b1;
    prep();
    vectors++; if (dut.discard !== 2'd2) begin miscompares++; $display("FAIL rd_discard got %0d exp 2", dut.discard); end
    for (int c = 0; c < 12 && !seen; c++) begin
      prep();
      if (id_valid_o) begin
        vectors++; if (id_pc_o !== 32'h0000_1000) begin miscompares++; $display("FAIL rd_pc got %h exp 00001000", id_pc_o); end
        vectors++; if (id_instr_o !== rdata_of(32'h0000_1000)) begin miscompares++; $display("FAIL rd_instr got %h exp %h", id_instr_o, rdata_of(32'h0000_1000)); end
        seen = 1;
      end
      adv();
      if (granted && !gseen) begin
        vectors++; if (gaddr !== 32'h0000_1000) begin miscompares++; $display("FAIL rd_first_req got %h exp 00001000", gaddr); end
        gseen = 1;
      end
    end
    vectors++; if (!(seen && gseen)) begin miscompares++; $display("FAIL rd_timeout got %0d/%0d exp 1/1", seen, gseen); end
  endtask

  task automatic test_redirect_rvalid();
    id_ready_i = 1'b0; fetch_enable_i = 1'b1; mem_gnt_en = 1'b1; mem_resp_en = 1'b0;
    do_reset(32'h8000_0000);
    prep(); adv(); prep(); adv();
    mem_gnt_en = 1'b0; mem_resp_en = 1'b1;
    prep(); adv();
    mem_resp_en = 1'b0;
    prep();
    vectors++; if (instr_req_o !== 1'b1) begin miscompares++; $display("FAIL rv_pending_req got %b exp 1", instr_req_o); end
    vectors++; if (instr_addr_o !== 32'h8000_0008) begin miscompares++; $display("FAIL rv_pending_addr got %h exp 80000008", instr_addr_o); end
    adv();
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_2000; mem_resp_en = 1'b1; mem_gnt_en = 1'b1;
    prep();
    vectors++; if (instr_req_o !== 1'b0) begin miscompares++; $display("FAIL rv_req got %b exp 0", instr_req_o); end
    vectors++; if (id_valid_o !== 1'b0) begin miscompares++; $display("FAIL rv_valid got %b exp 0", id_valid_o); end
    adv();
    redirect_i = 1'b0; mem_resp_en = 1'b0; mem_gnt_en = 1'b0;
    prep();
    vectors++; if (dut.discard !== 2'd0) begin miscompares++; $display("FAIL rv_discard got %0d exp 0", dut.discard); end
    vectors++; if (dut.outstanding !== 2'd0) begin miscompares++; $display("FAIL rv_out got %0d exp 0", dut.outstanding); end
    vectors++; if (dut.fifo_count !== 3'd0) begin miscompares++; $display("FAIL rv_count got %0d exp 0", dut.fifo_count); end
    vectors++; if (id_valid_o !== 1'b0) begin miscompares++; $display("FAIL rv_valid_after got %b exp 0", id_valid_o); end
    vectors++; if (instr_addr_o !== 32'h0000_2000) begin miscompares++; $display("FAIL rv_addr got %h exp 00002000", instr_addr_o); end
    adv();
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    id_ready_i = 1'b1; fetch_enable_i = 1'b1; mem_gnt_en = 1'b1; mem_resp_en = 1'b0;
    do_reset(32'h8000_0000);
    prep(); adv(); prep(); adv();
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_3000;
    prep(); adv();
    prep();
    vectors++; if (dut.discard !== 2'd2) begin miscompares++; $display("FAIL b2b_discard1 got %0d exp 2", dut.discard); end
    redirect_addr_i = 32'h0000_4000; mem_resp_en = 1'b1;
    prep(); adv();
    redirect_i = 1'b0;
    prep();
    vectors++; if (dut.discard !== 2'd1) begin miscompares++; $display("FAIL b2b_discard2 got %0d exp 1", dut.discard); end
    vectors++; if (instr_addr_o !== 32'h0000_4000) begin miscompares++; $display("FAIL b2b_addr got %h exp 00004000", instr_addr_o); end
    for (int c = 0; c < 12 && !seen; c++) begin
      prep();
      if (id_valid_o) begin
        vectors++; if (id_pc_o !== 32'h0000_4000) begin miscompares++; $display("FAIL b2b_pc got %h exp 00004000", id_pc_o); end
        seen = 1;
      end
      adv();
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL b2b_timeout got 0 exp 1"); end
  endtask

  task automatic test_fetch_disable();
    int got = 0;
    logic [31:0] exp;
    id_ready_i = 1'b1; fetch_enable_i = 1'b1; mem_gnt_en = 1'b1; mem_resp_en = 1'b0;
    do_reset(32'h8000_0000);
    prep(); adv(); prep(); adv();
    fetch_enable_i = 1'b0; mem_resp_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      prep();
      vectors++; if (instr_req_o !== 1'b0) begin miscompares++; $display("FAIL fd_req c%0d got %b exp 0", c, instr_req_o); end
      if (id_valid_o) begin
        exp = 32'h8000_0000 + 32'(4 * got);
        vectors++; if (id_pc_o !== exp) begin miscompares++; $display("FAIL fd_pc #%0d got %h exp %h", got, id_pc_o, exp); end
        got++;
      end
      adv();
    end
    prep();
    vectors++; if (got !== 2) begin miscompares++; $display("FAIL fd_delivered got %0d exp 2", got); end
    vectors++; if (dut.outstanding !== 2'd0) begin miscompares++; $display("FAIL fd_out got %0d exp 0", dut.outstanding); end
    adv();
  endtask

  task automatic test_wrap();
    int got = 0;
    logic [31:0] exp;
    id_ready_i = 1'b1; fetch_enable_i = 1'b1; mem_gnt_en = 1'b1; mem_resp_en = 1'b1;
    do_reset(32'hFFFF_FFF8);
    for (int c = 0; c < 10 && got < 3; c++) begin
      prep();
      if (id_valid_o) begin
        exp = 32'hFFFF_FFF8 + 32'(4 * got);
        vectors++; if (id_pc_o !== exp) begin miscompares++; $display("FAIL wrap_pc #%0d got %h exp %h", got, id_pc_o, exp); end
        vectors++; if (id_instr_o !== rdata_of(exp)) begin miscompares++; $display("FAIL wrap_instr #%0d got %h exp %h", got, id_instr_o, rdata_of(exp)); end
        got++;
      end
      adv();
    end
    vectors++; if (got !== 3) begin miscompares++; $display("FAIL wrap_delivered got %0d exp 3", got); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_i = 1'b1; boot_addr_i = '0; fetch_enable_i = 1'b0; redirect_i = 1'b0;
    redirect_addr_i = '0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    id_ready_i = 1'b0; mem_gnt_en = 1'b0; mem_resp_en = 1'b0; granted = 1'b0; gaddr = '0;
    @(negedge clk);
    test_reset();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_rvalid();
    test_back_to_back();
    test_fetch_disable();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
